// File: rtl/rv_pkg.sv
// Shared RV32IM data-bus constants used by the peripheral bus blocks.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = XLEN / 8;

    // Base address of the seven-digit HEX display peripheral.
    localparam logic [XLEN-1:0] ADDRESS_HEX = 32'h1000_0000;

endpackage

// File: rtl/rv_periph_bus_arbiter_if.sv
// Bundles both requester ports and the downstream slave port of the peripheral arbiter.
// Handshake: a requester holds mN_req_i (with stable fields) until a one-cycle mN_gnt_o;
// exactly one one-cycle mN_rvalid_o follows each grant. s_req_o is a one-cycle strobe that
// qualifies the s_* fields; s_rvalid_i is honoured only while a transaction is outstanding.
interface rv_periph_bus_arbiter_if;
    import rv_pkg::*;

    logic            m0_req_i;
    logic            m0_we_i;
    logic [BE_W-1:0] m0_be_i;
    logic [XLEN-1:0] m0_addr_i;
    logic [XLEN-1:0] m0_wdata_i;
    logic            m0_gnt_o;
    logic            m0_rvalid_o;
    logic [XLEN-1:0] m0_rdata_o;
    logic            m0_err_o;

    logic            m1_req_i;
    logic            m1_we_i;
    logic [BE_W-1:0] m1_be_i;
    logic [XLEN-1:0] m1_addr_i;
    logic [XLEN-1:0] m1_wdata_i;
    logic            m1_gnt_o;
    logic            m1_rvalid_o;
    logic [XLEN-1:0] m1_rdata_o;
    logic            m1_err_o;

    logic            s_req_o;
    logic            s_we_o;
    logic [BE_W-1:0] s_be_o;
    logic [XLEN-1:0] s_addr_o;
    logic [XLEN-1:0] s_wdata_o;
    logic            s_rvalid_i;
    logic [XLEN-1:0] s_rdata_i;

    // master: the arbiter, which masters the slave port and serves both requesters.
    modport master (
        input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
        input  s_rvalid_i, s_rdata_i
    );

    // slave: the surrounding system (requesters and the peripheral).
    modport slave (
        output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
        output s_rvalid_i, s_rdata_i
    );

endinterface

// File: rtl/rv_periph_bus_arbiter.sv
// Two-master round-robin arbiter for a single peripheral slave, one transaction in flight,
// with a watchdog that converts a silent slave into an error response.
module rv_periph_bus_arbiter
    import rv_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                    clk_i,
    input  logic                    arstn_i,
    rv_periph_bus_arbiter_if.master bus,
    output logic [1:0]              o_state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_grant;
    logic            w_winner;
    logic            w_resp;
    logic            w_resp_err;

    logic            w_sel_we;
    logic [BE_W-1:0] w_sel_be;
    logic [XLEN-1:0] w_sel_addr;
    logic [XLEN-1:0] w_sel_wdata;

    // Doubles as the owner of the transaction in flight once a grant is made.
    logic            r_last_owner;
    logic [CNT_W-1:0] r_cnt;

    logic            r_s_req;
    logic            r_s_we;
    logic [BE_W-1:0] r_s_be;
    logic [XLEN-1:0] r_s_addr;
    logic [XLEN-1:0] r_s_wdata;
    logic            r_gnt0;
    logic            r_gnt1;

    logic            r_rvalid0;
    logic            r_rvalid1;
    logic [XLEN-1:0] r_rdata0;
    logic [XLEN-1:0] r_rdata1;
    logic            r_err0;
    logic            r_err1;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_winner   = r_last_owner;
        w_resp     = 1'b0;
        w_resp_err = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the master that did not own the last grant wins.
                if (bus.m0_req_i && bus.m1_req_i) begin
                    w_winner = ~r_last_owner;
                end else begin
                    w_winner = bus.m1_req_i;
                end
                if (bus.m0_req_i || bus.m1_req_i) begin
                    w_grant = 1'b1;
                    w_next  = ISSUE;
                end
            end
            ISSUE: begin
                w_next = WAIT;
            end
            WAIT: begin
                if (bus.s_rvalid_i) begin
                    w_resp = 1'b1;
                    w_next = RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_resp     = 1'b1;
                    w_resp_err = 1'b1;
                    w_next     = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_sel_we    = w_winner ? bus.m1_we_i    : bus.m0_we_i;
    assign w_sel_be    = w_winner ? bus.m1_be_i    : bus.m0_be_i;
    assign w_sel_addr  = w_winner ? bus.m1_addr_i  : bus.m0_addr_i;
    assign w_sel_wdata = w_winner ? bus.m1_wdata_i : bus.m0_wdata_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_last_owner <= 1'b1;
            r_cnt        <= '0;
            r_s_req      <= 1'b0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_s_we       <= 1'b0;
            r_s_be       <= '0;
            r_s_addr     <= '0;
            r_s_wdata    <= '0;
        end else begin
            r_s_req <= w_grant;
            r_gnt0  <= w_grant & ~w_winner;
            r_gnt1  <= w_grant & w_winner;
            if (w_grant) begin
                r_last_owner <= w_winner;
                r_s_we       <= w_sel_we;
                r_s_be       <= w_sel_be;
                r_s_addr     <= w_sel_addr;
                r_s_wdata    <= w_sel_wdata;
            end
            if (r_state == ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Response fields persist per master until that master's next response.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_rvalid0 <= w_resp & ~r_last_owner;
            r_rvalid1 <= w_resp & r_last_owner;
            if (w_resp && !r_last_owner) begin
                r_rdata0 <= w_resp_err ? '0 : bus.s_rdata_i;
                r_err0   <= w_resp_err;
            end
            if (w_resp && r_last_owner) begin
                r_rdata1 <= w_resp_err ? '0 : bus.s_rdata_i;
                r_err1   <= w_resp_err;
            end
        end
    end

    assign bus.s_req_o     = r_s_req;
    assign bus.s_we_o      = r_s_we;
    assign bus.s_be_o      = r_s_be;
    assign bus.s_addr_o    = r_s_addr;
    assign bus.s_wdata_o   = r_s_wdata;
    assign bus.m0_gnt_o    = r_gnt0;
    assign bus.m1_gnt_o    = r_gnt1;
    assign bus.m0_rvalid_o = r_rvalid0;
    assign bus.m1_rvalid_o = r_rvalid1;
    assign bus.m0_rdata_o  = r_rdata0;
    assign bus.m1_rdata_o  = r_rdata1;
    assign bus.m0_err_o    = r_err0;
    assign bus.m1_err_o    = r_err1;
    assign o_state_dbg     = r_state;

endmodule

// File: tb/tb_rv_periph_bus_arbiter.sv
// Randomised self-checking bench for rv_periph_bus_arbiter against a rule-level model of
// arbitration order, response latency and timeout behaviour.
module tb_rv_periph_bus_arbiter;
    import rv_pkg::*;

    localparam int TIMEOUT = 16;

    typedef struct {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } txn_t;

    typedef struct {
        logic            got_req;
        int              req_wait;
        logic            gnt0;
        logic            gnt1;
        txn_t            s;
        logic            req_pulse;
        logic            got_rsp;
        int              rsp_cyc;
        logic            rv0;
        logic            rv1;
        logic [XLEN-1:0] rdata;
        logic            err;
        logic            rv_next;
        logic [XLEN-1:0] rdata_next;
        logic            err_next;
    } obs_t;

    logic       clk_i = 1'b0;
    logic       arstn_i;
    logic [1:0] state_dbg;
    int         total = 0;
    int         bad = 0;
    logic       model_last;

    rv_periph_bus_arbiter_if bus();

    rv_periph_bus_arbiter #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (8)
    ) dut (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .bus        (bus),
        .o_state_dbg(state_dbg)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "bench watchdog expired");
    end

    // Reference rules: a lone requester wins; on a tie the non-last owner wins.
    function automatic logic model_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    // Cycle of the master response counted from the s_req_o cycle, for a slave that
    // answers in WAIT cycle index dly (0 = first WAIT cycle).
    function automatic int model_rsp_cyc(input int dly);
        return 2 + ((dly < TIMEOUT - 1) ? dly : TIMEOUT - 1);
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.be    = BE_W'($urandom_range(1, (1 << BE_W) - 1));
        t.addr  = $urandom;
        t.wdata = $urandom;
        return t;
    endfunction

    task automatic set_master(input int n, input logic req, input txn_t t);
        if (n == 0) begin
            bus.m0_req_i = req; bus.m0_we_i = t.we; bus.m0_be_i = t.be;
            bus.m0_addr_i = t.addr; bus.m0_wdata_i = t.wdata;
        end else begin
            bus.m1_req_i = req; bus.m1_we_i = t.we; bus.m1_be_i = t.be;
            bus.m1_addr_i = t.addr; bus.m1_wdata_i = t.wdata;
        end
    endtask

    task automatic reset_dut();
        txn_t z;
        z = '{default: '0};
        arstn_i = 1'b0;
        set_master(0, 1'b0, z);
        set_master(1, 1'b0, z);
        bus.s_rvalid_i = 1'b0;
        bus.s_rdata_i  = '0;
        repeat (3) @(negedge clk_i);
        arstn_i    = 1'b1;
        model_last = 1'b1;
        @(negedge clk_i);
    endtask

    // Driver: issues one arbitration round, plays the slave, and records what it saw.
    task automatic drive_txn(input logic r0, input logic r1, input txn_t t0, input txn_t t1,
                             input int dly, input logic [XLEN-1:0] srd, output obs_t o);
        int i;
        o = '{default: '0};
        set_master(0, r0, t0);
        set_master(1, r1, t1);
        bus.s_rvalid_i = 1'b0;
        i = 0;
        while (!o.got_req && i < 10) begin
            @(negedge clk_i);
            i++;
            if (bus.s_req_o) begin
                o.got_req  = 1'b1;
                o.req_wait = i;
                o.gnt0     = bus.m0_gnt_o;
                o.gnt1     = bus.m1_gnt_o;
                o.s.we     = bus.s_we_o;
                o.s.be     = bus.s_be_o;
                o.s.addr   = bus.s_addr_o;
                o.s.wdata  = bus.s_wdata_o;
            end
        end
        if (o.got_req) begin
            if (o.gnt0) bus.m0_req_i = 1'b0;
            if (o.gnt1) bus.m1_req_i = 1'b0;
            i = 1;
            while (!o.got_rsp && i <= 40) begin
                @(negedge clk_i);
                if (i == 1) o.req_pulse = !bus.s_req_o && !bus.m0_gnt_o && !bus.m1_gnt_o;
                if (bus.m0_rvalid_o || bus.m1_rvalid_o) begin
                    o.got_rsp = 1'b1;
                    o.rsp_cyc = i;
                    o.rv0     = bus.m0_rvalid_o;
                    o.rv1     = bus.m1_rvalid_o;
                    o.rdata   = bus.m1_rvalid_o ? bus.m1_rdata_o : bus.m0_rdata_o;
                    o.err     = bus.m1_rvalid_o ? bus.m1_err_o : bus.m0_err_o;
                end
                bus.s_rvalid_i = (i == 1 + dly) && !o.got_rsp;
                bus.s_rdata_i  = (i == 1 + dly) ? srd : XLEN'($urandom);
                i++;
            end
            bus.s_rvalid_i = 1'b0;
            if (o.got_rsp) begin
                @(negedge clk_i);
                o.rv_next    = bus.m0_rvalid_o || bus.m1_rvalid_o;
                o.rdata_next = o.rv1 ? bus.m1_rdata_o : bus.m0_rdata_o;
                o.err_next   = o.rv1 ? bus.m1_err_o : bus.m0_err_o;
            end
        end
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({bus.s_req_o, bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {bus.s_req_o, bus.m0_gnt_o, bus.m1_gnt_o, bus.m0_rvalid_o, bus.m1_rvalid_o});
        end
        total++;
        if ({bus.s_we_o, bus.s_be_o, bus.s_addr_o, bus.s_wdata_o} !== '0) begin
            bad++;
            $display("FAIL reset_s_fields got=%h want=0", {bus.s_we_o, bus.s_be_o, bus.s_addr_o, bus.s_wdata_o});
        end
        total++;
        if ({bus.m0_rdata_o, bus.m0_err_o, bus.m1_rdata_o, bus.m1_err_o} !== '0) begin
            bad++;
            $display("FAIL reset_rsp got=%h want=0", {bus.m0_rdata_o, bus.m0_err_o, bus.m1_rdata_o, bus.m1_err_o});
        end
        total++;
        if (state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d want=0", state_dbg);
        end
    endtask

    task automatic test_single_write();
        obs_t o;
        txn_t t0;
        txn_t t1;
        logic [XLEN-1:0] srd;
        t0 = '{we: 1'b1, be: '1, addr: ADDRESS_HEX, wdata: 32'h1234_5678};
        t1 = rand_txn();
        srd = $urandom;
        drive_txn(1'b1, 1'b0, t0, t1, 0, srd, o);
        model_last = 1'b0;
        total++;
        if (o.got_req !== 1'b1 || o.req_wait != 1) begin
            bad++;
            $display("FAIL wr_req got=%b/%0d want=1/1", o.got_req, o.req_wait);
        end
        total++;
        if ({o.gnt0, o.gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL wr_gnt got=%b want=10", {o.gnt0, o.gnt1});
        end
        total++;
        if ({o.s.we, o.s.be, o.s.addr, o.s.wdata} !== {t0.we, t0.be, t0.addr, t0.wdata}) begin
            bad++;
            $display("FAIL wr_fields got=%h want=%h", {o.s.we, o.s.be, o.s.addr, o.s.wdata},
                     {t0.we, t0.be, t0.addr, t0.wdata});
        end
        total++;
        if (o.req_pulse !== 1'b1) begin
            bad++;
            $display("FAIL wr_req_pulse got=%b want=1", o.req_pulse);
        end
        total++;
        if (o.got_rsp !== 1'b1 || o.rsp_cyc != 2 || {o.rv0, o.rv1} !== 2'b10 || o.err !== 1'b0) begin
            bad++;
            $display("FAIL wr_rsp got=%b/%0d/%b%b/%b want=1/2/10/0", o.got_rsp, o.rsp_cyc, o.rv0, o.rv1, o.err);
        end
        total++;
        if (o.rv_next !== 1'b0) begin
            bad++;
            $display("FAIL wr_rvalid_len got=%b want=0", o.rv_next);
        end
    endtask

    task automatic test_alternate();
        obs_t o;
        logic exp_w;
        reset_dut();
        for (int n = 0; n < 8; n++) begin
            exp_w = model_pick(1'b1, 1'b1, model_last);
            drive_txn(1'b1, 1'b1, rand_txn(), rand_txn(), $urandom_range(0, 3), $urandom, o);
            model_last = exp_w;
            total++;
            if (o.got_req !== 1'b1 || {o.gnt0, o.gnt1} !== {!exp_w, exp_w}) begin
                bad++;
                $display("FAIL alt_gnt[%0d] got=%b/%b%b want=1/%b%b", n, o.got_req, o.gnt0, o.gnt1, !exp_w, exp_w);
            end
            total++;
            if (o.got_rsp !== 1'b1 || {o.rv0, o.rv1} !== {!exp_w, exp_w}) begin
                bad++;
                $display("FAIL alt_rsp[%0d] got=%b/%b%b want=1/%b%b", n, o.got_rsp, o.rv0, o.rv1, !exp_w, exp_w);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        txn_t t1;
        t1 = rand_txn();
        t1.we = 1'b0;
        drive_txn(1'b0, 1'b1, rand_txn(), t1, 1000, $urandom, o);
        model_last = 1'b1;
        total++;
        if (o.got_req !== 1'b1 || {o.gnt0, o.gnt1} !== 2'b01) begin
            bad++;
            $display("FAIL to_gnt got=%b/%b%b want=1/01", o.got_req, o.gnt0, o.gnt1);
        end
        total++;
        if (o.got_rsp !== 1'b1 || o.rsp_cyc != TIMEOUT + 1 || {o.rv0, o.rv1} !== 2'b01) begin
            bad++;
            $display("FAIL to_rsp got=%b/%0d/%b%b want=1/%0d/01", o.got_rsp, o.rsp_cyc, o.rv0, o.rv1, TIMEOUT + 1);
        end
        total++;
        if (o.err !== 1'b1 || o.rdata !== '0) begin
            bad++;
            $display("FAIL to_data got=%b/%h want=1/0", o.err, o.rdata);
        end
        total++;
        if (o.rv_next !== 1'b0 || o.err_next !== 1'b1 || o.rdata_next !== '0) begin
            bad++;
            $display("FAIL to_hold got=%b/%b/%h want=0/1/0", o.rv_next, o.err_next, o.rdata_next);
        end
    endtask

    task automatic test_late_response();
        obs_t o;
        txn_t t0;
        t0 = rand_txn();
        t0.we = 1'b0;
        drive_txn(1'b1, 1'b0, t0, rand_txn(), TIMEOUT - 1, 32'hDEAD_BEEF, o);
        model_last = 1'b0;
        total++;
        if (o.got_rsp !== 1'b1 || o.rsp_cyc != TIMEOUT + 1 || {o.rv0, o.rv1} !== 2'b10) begin
            bad++;
            $display("FAIL late_rsp got=%b/%0d/%b%b want=1/%0d/10", o.got_rsp, o.rsp_cyc, o.rv0, o.rv1, TIMEOUT + 1);
        end
        total++;
        if (o.err !== 1'b0 || o.rdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL late_data got=%b/%h want=0/deadbeef", o.err, o.rdata);
        end
        total++;
        if (o.rdata_next !== 32'hDEAD_BEEF || o.err_next !== 1'b0) begin
            bad++;
            $display("FAIL late_hold got=%h/%b want=deadbeef/0", o.rdata_next, o.err_next);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        txn_t t;
        logic seen;
        logic leak;
        int i;
        reset_dut();
        t = rand_txn();
        t.we = 1'b0;
        set_master(0, 1'b1, t);
        seen = 1'b0;
        i = 0;
        while (!seen && i < 10) begin
            @(negedge clk_i);
            i++;
            seen = bus.s_req_o;
        end
        set_master(0, 1'b0, t);
        total++;
        if (seen !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_issue got=%b want=1", seen);
        end
        repeat (3) @(negedge clk_i);
        arstn_i = 1'b0;
        #1;
        total++;
        if ({bus.s_req_o, bus.s_we_o, bus.s_be_o, bus.s_addr_o, bus.s_wdata_o, bus.m0_gnt_o, bus.m1_gnt_o,
             bus.m0_rvalid_o, bus.m1_rvalid_o, bus.m0_rdata_o, bus.m1_rdata_o, bus.m0_err_o, bus.m1_err_o,
             state_dbg} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=nonzero(state=%0d s_addr=%h) want=0", state_dbg, bus.s_addr_o);
        end
        @(negedge clk_i);
        arstn_i    = 1'b1;
        model_last = 1'b1;
        @(negedge clk_i);
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = $urandom;
        leak = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            bus.s_rvalid_i = 1'b0;
            leak |= bus.m0_rvalid_o | bus.m1_rvalid_o | bus.s_req_o | (state_dbg != 2'd0);
        end
        total++;
        if (leak !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_late_rsp got=%b want=0", leak);
        end
        drive_txn(1'b1, 1'b1, rand_txn(), rand_txn(), 1, 32'hCAFE_0001, o);
        model_last = 1'b0;
        total++;
        if (o.got_req !== 1'b1 || {o.gnt0, o.gnt1} !== 2'b10 || o.got_rsp !== 1'b1 || o.rdata !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL rst_mid_recover got=%b/%b%b/%b/%h want=1/10/1/cafe0001",
                     o.got_req, o.gnt0, o.gnt1, o.got_rsp, o.rdata);
        end
    endtask

    task automatic test_idle_rvalid();
        logic leak;
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = $urandom;
        leak = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            bus.s_rvalid_i = 1'b0;
            leak |= bus.m0_rvalid_o | bus.m1_rvalid_o | bus.s_req_o | (state_dbg != 2'd0);
        end
        total++;
        if (leak !== 1'b0) begin
            bad++;
            $display("FAIL idle_rvalid got=%b want=0", leak);
        end
    endtask

    task automatic test_random();
        obs_t o;
        txn_t t0;
        txn_t t1;
        txn_t tw;
        logic r0;
        logic r1;
        logic exp_w;
        logic exp_err;
        logic [XLEN-1:0] exp_rd;
        logic [XLEN-1:0] srd;
        int sel;
        int dly;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(1, 3);
            r0 = sel[0];
            r1 = sel[1];
            t0 = rand_txn();
            t1 = rand_txn();
            dly = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 5) : $urandom_range(0, TIMEOUT + 3);
            srd = $urandom;
            exp_w   = model_pick(r0, r1, model_last);
            exp_err = (dly > TIMEOUT - 1);
            exp_rd  = exp_err ? '0 : srd;
            tw      = exp_w ? t1 : t0;
            drive_txn(r0, r1, t0, t1, dly, srd, o);
            model_last = exp_w;
            total++;
            if (o.got_req !== 1'b1 || o.req_wait != 1 || {o.gnt0, o.gnt1} !== {!exp_w, exp_w}) begin
                bad++;
                $display("FAIL rnd_gnt[%0d] got=%b/%0d/%b%b want=1/1/%b%b", n, o.got_req, o.req_wait,
                         o.gnt0, o.gnt1, !exp_w, exp_w);
            end
            total++;
            if ({o.s.we, o.s.be, o.s.addr, o.s.wdata} !== {tw.we, tw.be, tw.addr, tw.wdata} || o.req_pulse !== 1'b1) begin
                bad++;
                $display("FAIL rnd_fields[%0d] got=%h/%b want=%h/1", n, {o.s.we, o.s.be, o.s.addr, o.s.wdata},
                         o.req_pulse, {tw.we, tw.be, tw.addr, tw.wdata});
            end
            total++;
            if (o.got_rsp !== 1'b1 || o.rsp_cyc != model_rsp_cyc(dly) || {o.rv0, o.rv1} !== {!exp_w, exp_w}) begin
                bad++;
                $display("FAIL rnd_rsp[%0d] got=%b/%0d/%b%b want=1/%0d/%b%b", n, o.got_rsp, o.rsp_cyc,
                         o.rv0, o.rv1, model_rsp_cyc(dly), !exp_w, exp_w);
            end
            total++;
            if (o.rdata !== exp_rd || o.err !== exp_err || o.rv_next !== 1'b0 ||
                o.rdata_next !== exp_rd || o.err_next !== exp_err) begin
                bad++;
                $display("FAIL rnd_data[%0d] got=%h/%b/%b/%h want=%h/%b/0/%h", n, o.rdata, o.err, o.rv_next,
                         o.rdata_next, exp_rd, exp_err, exp_rd);
            end
        end
    endtask

    initial begin
        arstn_i = 1'b0;
        reset_dut();
        test_reset();
        test_single_write();
        test_alternate();
        test_timeout();
        test_late_response();
        test_reset_mid();
        test_idle_rvalid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
